lock_controller: RTL and testbench
==================================

LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 The block SHALL have parameter CODE_LEN, default 4: number of 4-bit digits per code (2..8).
REQ-002 The block SHALL have parameter MAX_TRIES, default 3: consecutive wrong codes before lockout (1..3).
REQ-003 The block SHALL have parameter RESET_CODE, default 16'h1234: code after reset, first digit in the MS nibble, width 4*CODE_LEN.
REQ-004 The block SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have digit, input, 4 bits: keypad digit, sampled only when enter=1.
REQ-007 The block SHALL have enter, input, 1 bit: one-cycle pulse that submits digit.
REQ-008 The block SHALL have lock, input, 1 bit: relock request, honoured only in UNLOCKED.
REQ-009 The block SHALL have set_code, input, 1 bit: code-change request (see REQ-027).
REQ-010 The block SHALL have end_sleep, input, 1 bit: lockout-timer expiry from the downstream sleep timer.
REQ-011 The block SHALL have sleep, output, 1 bit: high for the whole lockout; starts the downstream timer.
REQ-012 The block SHALL have unlocked, output, 1 bit: high while in UNLOCKED.
REQ-013 The block SHALL have error, output, 1 bit: one-cycle pulse on a wrong code that does not trigger lockout.
REQ-014 The block SHALL have attempts, output, 2 bits: count of consecutive wrong codes.

Function
REQ-015 The FSM SHALL have states LOCKED, CHECK, UNLOCKED, SLEEP and PROGRAM (PROGRAM only when the REQ-027 macro is defined).
REQ-016 In LOCKED, enter with digit<=9 SHALL shift the digit into the entry register (new digit in the LS nibble) and increment the digit count.
REQ-017 An enter with digit>9 SHALL be ignored in every state: no shift, no count change.
REQ-018 The enter that completes CODE_LEN digits SHALL move the FSM to CHECK on the next edge and clear the digit count.
REQ-019 CHECK SHALL last exactly one cycle and compare the entry register with the code register.
REQ-020 On a match, CHECK SHALL go to UNLOCKED and clear attempts.
REQ-021 On a mismatch with attempts+1 < MAX_TRIES, CHECK SHALL increment attempts, pulse error for one cycle and return to LOCKED.
REQ-022 On a mismatch with attempts+1 == MAX_TRIES, CHECK SHALL go to SLEEP, set attempts to MAX_TRIES and raise sleep with no error pulse.
REQ-023 The path from the last enter to unlocked or sleep rising SHALL take exactly 2 clk edges.
REQ-024 In SLEEP, sleep SHALL stay 1 and enter, lock and set_code SHALL be ignored.
REQ-025 In SLEEP, end_sleep=1 on an edge SHALL, on that edge, drive sleep to 0, clear attempts and the entry register, and return to LOCKED.
REQ-026 In UNLOCKED, lock=1 SHALL return to LOCKED; if lock and set_code are both asserted, lock SHALL win; enter SHALL be ignored.

Reset
REQ-028 While reset=1, the block SHALL be in LOCKED with sleep=0, unlocked=0, error=0, attempts=0, entry register and digit count cleared, and code register = RESET_CODE.
REQ-029 An assertion of reset in any state, including mid-entry or mid-SLEEP, SHALL take effect immediately without waiting for clk.

Configuration
REQ-027 With LOCK_CODE_CHANGE_EN defined, set_code in UNLOCKED SHALL enter PROGRAM.
- PROGRAM collects CODE_LEN valid digits as in REQ-016.
- On the last digit, PROGRAM writes the code register and returns to UNLOCKED.
- unlocked stays 1 throughout PROGRAM.
- lock in PROGRAM aborts to LOCKED with the code unchanged.
- Without the macro, set_code SHALL be ignored, PROGRAM SHALL not exist and the code SHALL be fixed at RESET_CODE.

Verification
REQ-030 Correct code: pulse reset, enter 1,2,3,4 -> unlocked=1 exactly 2 edges after the 4th enter; attempts=0.
REQ-031 Wrong codes: enter 1,2,3,5 twice -> two single-cycle error pulses, attempts=1 then 2, unlocked=0.
REQ-032 Lockout: a third wrong code -> sleep=1, attempts=3, no error pulse; enters ignored; hold end_sleep=1 -> sleep=0 same edge, LOCKED, attempts=0; enter 1,2,3,4 -> unlocked.
REQ-033 Invalid digit: enter 1,A,2,3,4 -> A ignored, unlocked=1.
REQ-034 Code change (LOCK_CODE_CHANGE_EN only): unlock, set_code, enter 9,8,7,6, lock, enter 1,2,3,4 -> error pulse; enter 9,8,7,6 -> unlocked=1.
REQ-035 Async reset: assert reset mid-SLEEP between clk edges -> sleep=0 before the next edge; after release, code = 16'h1234.

Source files
------------

// File: rtl/lock_controller.sv
// Keypad lock: digit entry, code check, retry counting and sleep lockout.
// Define LOCK_CODE_CHANGE_EN to allow reprogramming the code from UNLOCKED.
module lock_controller #(
  parameter int                    CODE_LEN   = 4,
  parameter int                    MAX_TRIES  = 3,
  parameter logic [4*CODE_LEN-1:0] RESET_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       lock,
  input  logic       set_code,
  input  logic       end_sleep,
  output logic       sleep,
  output logic       unlocked,
  output logic       error,
  output logic [1:0] attempts
);

  localparam int W = 4 * CODE_LEN;

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    CHECK    = 3'd1,
    UNLOCKED = 3'd2,
    SLEEP    = 3'd3
`ifdef LOCK_CODE_CHANGE_EN
    , PROGRAM = 3'd4
`endif
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   entry_reg, entry_next;
  logic [3:0]     count_reg, count_next;
  logic [1:0]     attempts_reg, attempts_next;
  logic           error_reg, error_next;
  logic [W-1:0]   code;

  logic           digit_valid;
  logic           last_digit;
  logic [W-1:0]   shifted;
  logic [2:0]     tries;

  assign digit_valid = enter && (digit <= 4'd9);
  assign last_digit  = (count_reg == 4'(CODE_LEN - 1));
  assign shifted     = {entry_reg[W-5:0], digit};
  assign tries       = {1'b0, attempts_reg} + 3'd1;

`ifdef LOCK_CODE_CHANGE_EN
  logic [W-1:0] code_reg, code_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_reg <= RESET_CODE;
    end else begin
      code_reg <= code_next;
    end
  end

  assign code = code_reg;
`else
  logic unused_set_code;

  // Without reprogramming the code is a constant and set_code has no effect.
  assign code            = RESET_CODE;
  assign unused_set_code = set_code;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= LOCKED;
      entry_reg    <= '0;
      count_reg    <= '0;
      attempts_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      entry_reg    <= entry_next;
      count_reg    <= count_next;
      attempts_reg <= attempts_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    entry_next    = entry_reg;
    count_next    = count_reg;
    attempts_next = attempts_reg;
    error_next    = 1'b0;
`ifdef LOCK_CODE_CHANGE_EN
    code_next     = code_reg;
`endif

    case (state_reg)
      LOCKED: begin
        if (digit_valid) begin
          entry_next = shifted;
          if (last_digit) begin
            count_next = '0;
            state_next = CHECK;
          end else begin
            count_next = count_reg + 4'd1;
          end
        end
      end

      CHECK: begin
        if (entry_reg == code) begin
          state_next    = UNLOCKED;
          attempts_next = '0;
        end else if (tries < 3'(MAX_TRIES)) begin
          state_next    = LOCKED;
          attempts_next = tries[1:0];
          error_next    = 1'b1;
        end else begin
          // Final allowed miss: lockout replaces the error pulse.
          state_next    = SLEEP;
          attempts_next = 2'(MAX_TRIES);
        end
      end

      UNLOCKED: begin
        if (lock) begin
          state_next = LOCKED;
        end
`ifdef LOCK_CODE_CHANGE_EN
        else if (set_code) begin
          state_next = PROGRAM;
          count_next = '0;
        end
`endif
      end

      SLEEP: begin
        if (end_sleep) begin
          state_next    = LOCKED;
          attempts_next = '0;
          entry_next    = '0;
          count_next    = '0;
        end
      end

`ifdef LOCK_CODE_CHANGE_EN
      PROGRAM: begin
        if (lock) begin
          state_next = LOCKED;
          count_next = '0;
        end else if (digit_valid) begin
          entry_next = shifted;
          if (last_digit) begin
            count_next = '0;
            code_next  = shifted;
            state_next = UNLOCKED;
          end else begin
            count_next = count_reg + 4'd1;
          end
        end
      end
`endif

      default: begin
        state_next = LOCKED;
      end
    endcase
  end

  // sleep decodes the state directly so end_sleep and reset clear it at once.
  assign sleep    = (state_reg == SLEEP);
`ifdef LOCK_CODE_CHANGE_EN
  assign unlocked = (state_reg == UNLOCKED) || (state_reg == PROGRAM);
`else
  assign unlocked = (state_reg == UNLOCKED);
`endif
  assign error    = error_reg;
  assign attempts = attempts_reg;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller: unlock, retries, lockout, invalid digits,
// relock, asynchronous reset and (with LOCK_CODE_CHANGE_EN) code change.
module tb_lock_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       enter = 1'b0;
  logic       lock = 1'b0;
  logic       set_code = 1'b0;
  logic       end_sleep = 1'b0;
  logic       sleep;
  logic       unlocked;
  logic       error;
  logic [1:0] attempts;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lock_controller #(
    .CODE_LEN  (4),
    .MAX_TRIES (3),
    .RESET_CODE(16'h1234)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digit    (digit),
    .enter    (enter),
    .lock     (lock),
    .set_code (set_code),
    .end_sleep(end_sleep),
    .sleep    (sleep),
    .unlocked (unlocked),
    .error    (error),
    .attempts (attempts)
  );

  // One enter pulse; returns at the falling edge after the sampling edge.
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    digit = d;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    $display("[TB] enter digit %h -> unlocked=%b sleep=%b error=%b attempts=%0d",
             d, unlocked, sleep, error, attempts);
  endtask

  task automatic enter_code(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    for (int i = 0; i < 4; i++) begin
      press(v[15:12]);
      v = v << 4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({sleep, unlocked, error, attempts} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got sleep=%b unlocked=%b error=%b attempts=%0d, want all 0",
               sleep, unlocked, error, attempts);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_correct_code();
    do_reset();
    enter_code(16'h1234);
    tests_run++;
    if (unlocked !== 1'b0) begin
      tests_failed++;
      $display("FAIL unlock_latency_early: unlocked=%b after 1 edge, want 0", unlocked);
    end
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1 || attempts !== 2'd0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL unlock_after_2_edges: unlocked=%b attempts=%0d error=%b, want 1 0 0",
               unlocked, attempts, error);
    end
  endtask

  task automatic test_wrong_codes();
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      enter_code(16'h1235);
      tests_run++;
      if (error !== 1'b0) begin
        tests_failed++;
        $display("FAIL wrong_error_early: error=%b after 1 edge, want 0", error);
      end
      @(negedge clk);
      tests_run++;
      if (error !== 1'b1 || attempts !== 2'(i) || unlocked !== 1'b0) begin
        tests_failed++;
        $display("FAIL wrong_code_%0d: error=%b attempts=%0d unlocked=%b, want 1 %0d 0",
                 i, error, attempts, unlocked, i);
      end
      @(negedge clk);
      tests_run++;
      if (error !== 1'b0) begin
        tests_failed++;
        $display("FAIL error_one_cycle_%0d: error=%b, want 0", i, error);
      end
    end
  endtask

  // Continues from attempts=2 left by test_wrong_codes.
  task automatic test_lockout();
    enter_code(16'h1235);
    @(negedge clk);
    tests_run++;
    if (sleep !== 1'b1 || attempts !== 2'd3 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL lockout_enter: sleep=%b attempts=%0d error=%b, want 1 3 0",
               sleep, attempts, error);
    end
    enter_code(16'h1234);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (sleep !== 1'b1 || unlocked !== 1'b0 || attempts !== 2'd3) begin
      tests_failed++;
      $display("FAIL sleep_ignores_enter: sleep=%b unlocked=%b attempts=%0d, want 1 0 3",
               sleep, unlocked, attempts);
    end
    end_sleep = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (sleep !== 1'b0 || attempts !== 2'd0) begin
      tests_failed++;
      $display("FAIL end_sleep_same_edge: sleep=%b attempts=%0d, want 0 0", sleep, attempts);
    end
    @(negedge clk);
    end_sleep = 1'b0;
    enter_code(16'h1234);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL unlock_after_sleep: unlocked=%b, want 1", unlocked);
    end
  endtask

  task automatic test_invalid_digit();
    do_reset();
    press(4'h1);
    press(4'hA);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL invalid_digit_ignored: unlocked=%b error=%b, want 1 0", unlocked, error);
    end
  endtask

  // Starts in UNLOCKED from test_invalid_digit.
  task automatic test_relock();
    press(4'h5);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL unlocked_ignores_enter: unlocked=%b, want 1", unlocked);
    end
`ifndef LOCK_CODE_CHANGE_EN
    set_code = 1'b1;
    @(negedge clk);
    set_code = 1'b0;
    enter_code(16'h9876);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_code_ignored: unlocked=%b, want 1", unlocked);
    end
`endif
    lock = 1'b1;
    set_code = 1'b1;
    @(negedge clk);
    lock = 1'b0;
    set_code = 1'b0;
    tests_run++;
    if (unlocked !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_wins: unlocked=%b, want 0", unlocked);
    end
    enter_code(16'h1234);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL unlock_after_relock: unlocked=%b, want 1", unlocked);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    press(4'h1);
    press(4'h2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    enter_code(16'h1234);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_entry: unlocked=%b, want 1", unlocked);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enter_code(16'h1235);
      @(negedge clk);
    end
    tests_run++;
    if (sleep !== 1'b1) begin
      tests_failed++;
      $display("FAIL reach_sleep: sleep=%b, want 1", sleep);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (sleep !== 1'b0 || attempts !== 2'd0 || unlocked !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_sleep: sleep=%b attempts=%0d unlocked=%b, want 0 0 0",
               sleep, attempts, unlocked);
    end
    @(negedge clk);
    reset = 1'b0;
    enter_code(16'h1234);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL code_after_reset: unlocked=%b, want 1", unlocked);
    end
  endtask

`ifdef LOCK_CODE_CHANGE_EN
  task automatic test_code_change();
    do_reset();
    enter_code(16'h1234);
    @(negedge clk);
    set_code = 1'b1;
    @(negedge clk);
    set_code = 1'b0;
    enter_code(16'h9876);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL program_unlocked: unlocked=%b, want 1", unlocked);
    end
    lock = 1'b1;
    @(negedge clk);
    lock = 1'b0;
    enter_code(16'h1234);
    @(negedge clk);
    tests_run++;
    if (error !== 1'b1 || unlocked !== 1'b0) begin
      tests_failed++;
      $display("FAIL old_code_rejected: error=%b unlocked=%b, want 1 0", error, unlocked);
    end
    enter_code(16'h9876);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL new_code_accepted: unlocked=%b, want 1", unlocked);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_codes();
    test_lockout();
    test_invalid_digit();
    test_relock();
    test_async_reset();
`ifdef LOCK_CODE_CHANGE_EN
    test_code_change();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
